// File: rtl/iahb_mem_arb.sv
// Two-master AHB-lite arbiter for the SRAM slave: round-robin with SEQ burst hold (BURST_MAX beats).
// Zero added latency when uncontested; losers and slave stalls push back via mX_hready; ARB_PERF_CNT_EN adds stall counters.
module iahb_mem_arb #(
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst,
  input  logic                  m0_hsel,
  input  logic [31:0]           m0_haddr,
  input  logic [2:0]            m0_hsize,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [31:0]           m0_hwdata,
  output logic [31:0]           m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic                  m1_hsel,
  input  logic [31:0]           m1_haddr,
  input  logic [2:0]            m1_hsize,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [31:0]           m1_hwdata,
  output logic [31:0]           m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic                  arb_mmc_hsel,
  output logic [31:0]           arb_yy_haddr,
  output logic [2:0]            arb_yy_hsize,
  output logic [1:0]            arb_yy_htrans,
  output logic                  arb_yy_hwrite,
  output logic [31:0]           arb_yy_hwdata,
  input  logic [31:0]           mmc_arb_hrdata,
  input  logic                  mmc_arb_hready,
  input  logic                  mmc_arb_hresp,
  output logic [PERF_CNT_W-1:0] arb_m0_stall_cnt,
  output logic [PERF_CNT_W-1:0] arb_m1_stall_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic [1:0] HT_SEQ    = 2'b11;

  logic        last_gnt_q, last_gnt_d;
  logic        dp_vld_q, dp_vld_d;
  logic        dp_own_q, dp_own_d;
  logic        lock_own_q, lock_own_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        fwd_hsel_q, fwd_hsel_d;
  logic [31:0] fwd_haddr_q, fwd_haddr_d;
  logic [2:0]  fwd_hsize_q, fwd_hsize_d;
  logic [1:0]  fwd_htrans_q, fwd_htrans_d;
  logic        fwd_hwrite_q, fwd_hwrite_d;

  logic req0, req1, gnt0, gnt1, lock_seq, gnt_seq;

  assign req0 = m0_hsel & m0_htrans[1];
  assign req1 = m1_hsel & m1_htrans[1];

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    lock_seq = lock_own_q ? (m1_htrans == HT_SEQ) : (m0_htrans == HT_SEQ);
    if (!pad_cpu_rst && mmc_arb_hready) begin
      if (req0 && req1) begin
        // Burst owner keeps the port until BURST_MAX beats, then the other master gets a turn.
        if (lock_seq && (burst_cnt_q < BURST_LIM)) begin
          gnt0 = !lock_own_q;
          gnt1 = lock_own_q;
        end else begin
          gnt0 = last_gnt_q;
          gnt1 = !last_gnt_q;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    fwd_hsel_d   = 1'b0;
    fwd_haddr_d  = '0;
    fwd_hsize_d  = '0;
    fwd_htrans_d = '0;
    fwd_hwrite_d = 1'b0;
    if (!pad_cpu_rst) begin
      if (!mmc_arb_hready) begin
        fwd_hsel_d   = fwd_hsel_q;
        fwd_haddr_d  = fwd_haddr_q;
        fwd_hsize_d  = fwd_hsize_q;
        fwd_htrans_d = fwd_htrans_q;
        fwd_hwrite_d = fwd_hwrite_q;
      end else if (gnt0) begin
        fwd_hsel_d   = 1'b1;
        fwd_haddr_d  = m0_haddr;
        fwd_hsize_d  = m0_hsize;
        fwd_htrans_d = m0_htrans;
        fwd_hwrite_d = m0_hwrite;
      end else if (gnt1) begin
        fwd_hsel_d   = 1'b1;
        fwd_haddr_d  = m1_haddr;
        fwd_hsize_d  = m1_hsize;
        fwd_htrans_d = m1_htrans;
        fwd_hwrite_d = m1_hwrite;
      end
    end
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    dp_vld_d    = dp_vld_q;
    dp_own_d    = dp_own_q;
    lock_own_d  = lock_own_q;
    burst_cnt_d = burst_cnt_q;
    gnt_seq     = gnt1 ? (m1_htrans == HT_SEQ) : (m0_htrans == HT_SEQ);
    if (mmc_arb_hready) begin
      dp_vld_d = gnt0 | gnt1;
      if (gnt0 || gnt1) begin
        last_gnt_d = gnt1;
        dp_own_d   = gnt1;
        lock_own_d = gnt1;
        if (gnt_seq && (gnt1 == lock_own_q)) begin
          burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      last_gnt_q   <= 1'b1;
      dp_vld_q     <= 1'b0;
      dp_own_q     <= 1'b0;
      lock_own_q   <= 1'b0;
      burst_cnt_q  <= '0;
      fwd_hsel_q   <= 1'b0;
      fwd_haddr_q  <= '0;
      fwd_hsize_q  <= '0;
      fwd_htrans_q <= '0;
      fwd_hwrite_q <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      dp_vld_q     <= dp_vld_d;
      dp_own_q     <= dp_own_d;
      lock_own_q   <= lock_own_d;
      burst_cnt_q  <= burst_cnt_d;
      fwd_hsel_q   <= fwd_hsel_d;
      fwd_haddr_q  <= fwd_haddr_d;
      fwd_hsize_q  <= fwd_hsize_d;
      fwd_htrans_q <= fwd_htrans_d;
      fwd_hwrite_q <= fwd_hwrite_d;
    end
  end

  assign arb_mmc_hsel  = fwd_hsel_d;
  assign arb_yy_haddr  = fwd_haddr_d;
  assign arb_yy_hsize  = fwd_hsize_d;
  assign arb_yy_htrans = fwd_htrans_d;
  assign arb_yy_hwrite = fwd_hwrite_d;
  assign arb_yy_hwdata = (!pad_cpu_rst && dp_vld_q) ? (dp_own_q ? m1_hwdata : m0_hwdata) : '0;

  assign m0_hready = pad_cpu_rst | (!(req0 & !gnt0) & !(dp_vld_q & !dp_own_q & !mmc_arb_hready));
  assign m1_hready = pad_cpu_rst | (!(req1 & !gnt1) & !(dp_vld_q & dp_own_q & !mmc_arb_hready));
  assign m0_hresp  = !pad_cpu_rst & dp_vld_q & !dp_own_q & mmc_arb_hresp;
  assign m1_hresp  = !pad_cpu_rst & dp_vld_q & dp_own_q & mmc_arb_hresp;
  assign m0_hrdata = mmc_arb_hrdata;
  assign m1_hrdata = mmc_arb_hrdata;

`ifdef ARB_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall0_q, stall1_q;

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (!m0_hready && (stall0_q != '1)) stall0_q <= stall0_q + PERF_CNT_W'(1);
      if (!m1_hready && (stall1_q != '1)) stall1_q <= stall1_q + PERF_CNT_W'(1);
    end
  end

  assign arb_m0_stall_cnt = stall0_q;
  assign arb_m1_stall_cnt = stall1_q;
`else
  assign arb_m0_stall_cnt = '0;
  assign arb_m1_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_iahb_mem_arb.sv
// Bench for iahb_mem_arb: directed scenarios plus random traffic, all outputs checked
// every cycle against a transaction-level arbitration model.
module tb_iahb_mem_arb;
  localparam int BMAX = 4;
  localparam int CW   = 32;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
`ifdef ARB_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel[2];
  logic [31:0] haddr[2];
  logic [2:0]  hsize[2];
  logic [1:0]  htrans[2];
  logic        hwrite[2];
  logic [31:0] hwdata[2];
  logic [31:0] hrdata_o[2];
  logic        hready_o[2];
  logic        hresp_o[2];
  logic [CW-1:0] stall_o[2];
  logic        s_hready, s_hresp;
  logic [31:0] s_hrdata;
  logic        a_hsel, a_hwrite;
  logic [31:0] a_haddr, a_hwdata;
  logic [2:0]  a_hsize;
  logic [1:0]  a_htrans;

  iahb_mem_arb #(.BURST_MAX(BMAX), .PERF_CNT_W(CW)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
    .m0_hsel(hsel[0]), .m0_haddr(haddr[0]), .m0_hsize(hsize[0]), .m0_htrans(htrans[0]),
    .m0_hwrite(hwrite[0]), .m0_hwdata(hwdata[0]), .m0_hrdata(hrdata_o[0]),
    .m0_hready(hready_o[0]), .m0_hresp(hresp_o[0]),
    .m1_hsel(hsel[1]), .m1_haddr(haddr[1]), .m1_hsize(hsize[1]), .m1_htrans(htrans[1]),
    .m1_hwrite(hwrite[1]), .m1_hwdata(hwdata[1]), .m1_hrdata(hrdata_o[1]),
    .m1_hready(hready_o[1]), .m1_hresp(hresp_o[1]),
    .arb_mmc_hsel(a_hsel), .arb_yy_haddr(a_haddr), .arb_yy_hsize(a_hsize),
    .arb_yy_htrans(a_htrans), .arb_yy_hwrite(a_hwrite), .arb_yy_hwdata(a_hwdata),
    .mmc_arb_hrdata(s_hrdata), .mmc_arb_hready(s_hready), .mmc_arb_hresp(s_hresp),
    .arb_m0_stall_cnt(stall_o[0]), .arb_m1_stall_cnt(stall_o[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owned the last grant, how long the current run is, and the open data phase.
  int          m_last, m_lock, m_run, m_dpv, m_dpo;
  longint      m_stall[2];
  logic        h_sel, h_write;
  logic [31:0] h_addr;
  logic [2:0]  h_size;
  logic [1:0]  h_trans;
  bit          rdy_seen[2];
  logic        snap_sel, snap_write;
  logic [31:0] snap_addr, snap_wd;
  logic        snap_rdy[2];
  logic [CW-1:0] snap_stall[2];
  logic [31:0] exp3[4] = '{32'h400, 32'h800, 32'h404, 32'h804};
  logic [31:0] exp4[7] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300, 32'h210, 32'h214};

  task automatic mdl_reset();
    m_last = 1; m_lock = 0; m_run = 0; m_dpv = 0; m_dpo = 0;
    m_stall[0] = 0; m_stall[1] = 0;
    h_sel = 0; h_addr = 0; h_size = 0; h_trans = 0; h_write = 0;
  endtask

  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) begin
      if (htrans[m_lock] == SEQ && m_run < BMAX) return m_lock;
      return 1 - m_last;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic cycle();
    int w;
    bit r[2];
    bit e_rdy[2], e_resp[2];
    logic e_sel, e_write;
    logic [31:0] e_addr, e_wd;
    logic [2:0] e_size;
    logic [1:0] e_trans;
    longint e_cnt;
    #3;
    for (int x = 0; x < 2; x++) r[x] = hsel[x] && htrans[x][1];
    w = -1;
    e_sel = 0; e_addr = 0; e_size = 0; e_trans = 0; e_write = 0; e_wd = 0;
    e_rdy[0] = 1; e_rdy[1] = 1; e_resp[0] = 0; e_resp[1] = 0;
    if (!rst) begin
      if (s_hready) begin
        w = pick(r[0], r[1]);
        if (w >= 0) begin
          e_sel = 1; e_addr = haddr[w]; e_size = hsize[w]; e_trans = htrans[w]; e_write = hwrite[w];
        end
      end else begin
        e_sel = h_sel; e_addr = h_addr; e_size = h_size; e_trans = h_trans; e_write = h_write;
      end
      if (m_dpv != 0) e_wd = hwdata[m_dpo];
      for (int x = 0; x < 2; x++) begin
        e_rdy[x]  = !(r[x] && w != x) && !(m_dpv != 0 && m_dpo == x && !s_hready);
        e_resp[x] = (m_dpv != 0) && m_dpo == x && s_hresp;
      end
    end
    chk("hsel", a_hsel, e_sel);
    chk("haddr", a_haddr, e_addr);
    chk("hsize", a_hsize, e_size);
    chk("htrans", a_htrans, e_trans);
    chk("hwrite", a_hwrite, e_write);
    chk("hwdata", a_hwdata, e_wd);
    for (int x = 0; x < 2; x++) begin
      e_cnt = CNT_ON ? m_stall[x] : 0;
      chk($sformatf("hready%0d", x), hready_o[x], e_rdy[x]);
      chk($sformatf("hresp%0d", x), hresp_o[x], e_resp[x]);
      chk($sformatf("hrdata%0d", x), hrdata_o[x], s_hrdata);
      chk($sformatf("stall%0d", x), stall_o[x], e_cnt);
      rdy_seen[x]   = e_rdy[x];
      snap_rdy[x]   = hready_o[x];
      snap_stall[x] = stall_o[x];
    end
    snap_sel = a_hsel; snap_addr = a_haddr; snap_wd = a_hwdata; snap_write = a_hwrite;
    @(posedge clk);
    if (rst) mdl_reset();
    else begin
      for (int x = 0; x < 2; x++)
        if (!e_rdy[x] && m_stall[x] < ((64'd1 << CW) - 1)) m_stall[x]++;
      if (s_hready) begin
        h_sel = e_sel; h_addr = e_addr; h_size = e_size; h_trans = e_trans; h_write = e_write;
        m_dpv = (w >= 0) ? 1 : 0;
        if (w >= 0) begin
          if (htrans[w] == SEQ && w == m_lock) m_run = (m_run >= 15) ? 15 : m_run + 1;
          else m_run = 1;
          m_last = w; m_lock = w; m_dpo = w;
        end
      end
    end
    #1;
  endtask

  task automatic drv(input int x, input bit sel, input logic [1:0] tr, input logic [31:0] ad,
                     input bit wr, input logic [31:0] wd);
    hsel[x] = sel; htrans[x] = tr; haddr[x] = ad; hsize[x] = 3'd2; hwrite[x] = wr; hwdata[x] = wd;
  endtask

  task automatic do_reset();
    rst = 1;
    drv(0, 0, IDLE, 0, 0, 0);
    drv(1, 0, IDLE, 0, 0, 0);
    s_hready = 1; s_hresp = 0;
    cycle();
    rst = 0;
  endtask

  initial begin
    int k0, k1, b1;
    bit m0_done;
    rst = 1; s_hready = 1; s_hresp = 0; s_hrdata = 0;
    drv(0, 0, IDLE, 0, 0, 0);
    drv(1, 0, IDLE, 0, 0, 0);
    @(posedge clk);
    #1;
    mdl_reset();
    do_reset();

    // Lone m0 read goes straight through in the same cycle.
    drv(0, 1, NSEQ, 32'h100, 0, 0);
    cycle();
    chk("t1_hsel", snap_sel, 1);
    chk("t1_haddr", snap_addr, 32'h100);
    chk("t1_rdy0", snap_rdy[0], 1);
    chk("t1_rdy1", snap_rdy[1], 1);

    // First tie after reset goes to m0; m1 follows; m1 write data one cycle later.
    do_reset();
    drv(0, 1, NSEQ, 32'h10, 0, 0);
    drv(1, 1, NSEQ, 32'h20, 1, 32'hA5A5_0001);
    cycle();
    chk("t2_c0_haddr", snap_addr, 32'h10);
    chk("t2_c0_rdy1", snap_rdy[1], 0);
    drv(0, 0, IDLE, 0, 0, 0);
    cycle();
    chk("t2_c1_haddr", snap_addr, 32'h20);
    chk("t2_c1_hwrite", snap_write, 1);
    drv(1, 0, IDLE, 0, 0, 32'hA5A5_0001);
    cycle();
    chk("t2_c2_hwdata", snap_wd, 32'hA5A5_0001);

    // Continuous NONSEQ from both alternates.
    do_reset();
    k0 = 0; k1 = 0;
    for (int c = 0; c < 4; c++) begin
      drv(0, 1, NSEQ, 32'h400 + 32'(4 * k0), 0, 0);
      drv(1, 1, NSEQ, 32'h800 + 32'(4 * k1), 0, 0);
      cycle();
      chk($sformatf("t3_haddr%0d", c), snap_addr, exp3[c]);
      if (rdy_seen[0]) k0++;
      if (rdy_seen[1]) k1++;
    end
    drv(0, 0, IDLE, 0, 0, 0);
    drv(1, 0, IDLE, 0, 0, 0);
    cycle();
    chk("t3_stall0", snap_stall[0], CNT_ON ? 2 : 0);
    chk("t3_stall1", snap_stall[1], CNT_ON ? 2 : 0);

    // m1 six-beat burst is cut after BURST_MAX beats to let waiting m0 in once.
    do_reset();
    b1 = 0; m0_done = 0;
    for (int c = 0; c < 7; c++) begin
      if (b1 < 6) drv(1, 1, (b1 == 0) ? NSEQ : SEQ, 32'h200 + 32'(4 * b1), 0, 0);
      else drv(1, 0, IDLE, 0, 0, 0);
      if (c >= 1 && !m0_done) drv(0, 1, NSEQ, 32'h300, 0, 0);
      else drv(0, 0, IDLE, 0, 0, 0);
      cycle();
      chk($sformatf("t4_haddr%0d", c), snap_addr, exp4[c]);
      if (hsel[1] && rdy_seen[1]) b1++;
      if (hsel[0] && rdy_seen[0]) m0_done = 1;
    end

    // Slave stall during m0 data phase freezes the forwarded bus and blocks m1.
    do_reset();
    drv(0, 1, NSEQ, 32'h500, 0, 0);
    cycle();
    drv(0, 0, IDLE, 0, 0, 0);
    drv(1, 1, NSEQ, 32'h600, 0, 0);
    s_hready = 0;
    cycle();
    chk("t5_hsel", snap_sel, 1);
    chk("t5_haddr", snap_addr, 32'h500);
    chk("t5_rdy0", snap_rdy[0], 0);
    chk("t5_rdy1", snap_rdy[1], 0);
    s_hready = 1;
    cycle();
    chk("t5_fwd", snap_addr, 32'h600);

    // Reset in the middle of contention.
    do_reset();
    drv(0, 1, NSEQ, 32'h700, 0, 0);
    drv(1, 1, NSEQ, 32'h900, 0, 0);
    cycle();
    cycle();
    rst = 1;
    cycle();
    chk("t6_hsel", snap_sel, 0);
    chk("t6_rdy0", snap_rdy[0], 1);
    chk("t6_rdy1", snap_rdy[1], 1);
    rst = 0;
    cycle();
    chk("t6_haddr", snap_addr, 32'h700);
    chk("t6_stall0", snap_stall[0], 0);
    chk("t6_stall1", snap_stall[1], 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 64) == 0;
      for (int x = 0; x < 2; x++) begin
        drv(x, ($urandom % 4) != 0, 2'($urandom % 4), $urandom, 1'($urandom % 2), $urandom);
        hsize[x] = 3'($urandom % 8);
      end
      s_hready = ($urandom % 5) != 0;
      s_hresp  = ($urandom % 8) == 0;
      s_hrdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
